// File: rtl/fruit_stream_core_if.sv
// Request / keystream bundle between the key-IV register file, fruit_stream_core
// and the datapath XOR stage.
// Optional macro FRUIT_XOR_EN adds the din/dout XOR data path to the bundle.
interface fruit_stream_core_if #(
  parameter int OUT_W = 8,
  parameter int IV_W  = 70
);
  logic             start;
  logic [0:79]      key;
  logic [0:IV_W-1]  iv;
  logic             busy;
  logic             ready;
  logic [OUT_W-1:0] ks_data;
  logic             ks_valid;
  logic             ks_ready;
`ifdef FRUIT_XOR_EN
  logic [OUT_W-1:0] din;
  logic [OUT_W-1:0] dout;

  modport master (
    output start, key, iv, ks_ready, din,
    input  busy, ready, ks_data, ks_valid, dout
  );

  modport slave (
    input  start, key, iv, ks_ready, din,
    output busy, ready, ks_data, ks_valid, dout
  );
`else
  modport master (
    output start, key, iv, ks_ready,
    input  busy, ready, ks_data, ks_valid
  );

  modport slave (
    input  start, key, iv, ks_ready,
    output busy, ready, ks_data, ks_valid
  );
`endif
endinterface

// File: rtl/fruit_stream_core.sv
// Fruit-80 keystream generator with start/busy handshake, configurable
// initialisation length and OUT_W-bit word packing behind valid/ready.
// Optional macro FRUIT_XOR_EN: adds din/dout, dout = din ^ ks_data while ks_valid.
module fruit_stream_core #(
  parameter int OUT_W       = 8,
  parameter int IV_W        = 70,
  parameter int INIT_ROUNDS = 130
) (
  input  logic               clk,
  input  logic               rst,
  fruit_stream_core_if.slave bus
);

  localparam int RW = $clog2(INIT_ROUNDS + 1);
  localparam int BW = $clog2(OUT_W + 1);

  localparam logic [RW-1:0] LAST_RND = RW'(INIT_ROUNDS - 1);
  localparam logic [RW-1:0] IV_RNDS  = RW'(80);
  localparam logic [BW-1:0] FULL     = BW'(OUT_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_INIT = 2'd2;
  localparam logic [1:0] S_KS   = 2'd3;

  logic [1:0]       state;
  logic [0:36]      n;
  logic [0:42]      l;
  logic [0:6]       c;
  logic [0:79]      kreg;
  logic [0:79]      ivreg;
  logic [RW-1:0]    rnd;
  logic [BW-1:0]    bcnt;
  logic [OUT_W-1:0] pack;

  logic [6:0] idx_r;
  logic [6:0] idx_p;
  logic [6:0] idx_q;
  logic       kt;
  logic       kt1;
  logic       f;
  logic       g;
  logic       h;
  logic       z;
  logic       iv_bit;
  logic       last_rnd;
  logic       ks_valid;
  logic       accept;
  logic       ks_step;
  logic       rekey;

  // Round-key selectors are slices of the counter, widened to 7-bit key indices.
  always_comb begin
    idx_r = {3'b000, c[0:3]};
    idx_p = {2'b00, c[1:5]} + 7'd16;
    idx_q = {2'b00, c[2:6]} + 7'd48;
  end

  // Fruit-80 round-key bits, feedback functions and keystream output bit.
  always_comb begin
    kt  = (kreg[idx_r] & kreg[idx_p]) ^ kreg[idx_q] ^ kreg[idx_p];
    kt1 = (kreg[idx_r] & kreg[idx_p]) ^ (kreg[idx_p] & kreg[idx_q])
        ^ kreg[idx_r] ^ kreg[idx_q];
    f   = l[0] ^ l[8] ^ l[18] ^ l[23] ^ l[28] ^ l[37];
    g   = kt ^ l[0] ^ c[3] ^ n[0] ^ n[10] ^ n[20]
        ^ (n[12] & n[3]) ^ (n[14] & n[25]) ^ (n[5] & n[23] & n[31])
        ^ (n[8] & n[18] & n[28] & n[30] & n[32] & n[34]);
    h   = (kt1 & (n[36] ^ l[19])) ^ (l[6] & l[15]) ^ (l[1] & l[22])
        ^ (n[35] & l[27]) ^ (n[1] & n[24]) ^ (n[1] & n[33] & l[42]);
    z   = h ^ n[0] ^ n[7] ^ n[19] ^ n[29] ^ n[36] ^ l[38];
  end

  // Handshake decode: a word may be consumed and refilled in the same cycle,
  // and a rekey request in KEYSTREAM suppresses stepping.
  always_comb begin
    iv_bit   = (rnd < IV_RNDS) ? ivreg[rnd[6:0]] : 1'b0;
    last_rnd = (rnd == LAST_RND);
    ks_valid = (bcnt == FULL);
    accept   = ks_valid && bus.ks_ready;
    rekey    = (state == S_KS) && bus.start;
    ks_step  = (state == S_KS) && !bus.start && ((bcnt < FULL) || accept);
  end

  // Control FSM: sample key/IV on start, count init rounds, enter KEYSTREAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      kreg  <= '0;
      ivreg <= '0;
      rnd   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            kreg  <= bus.key;
            ivreg <= {1'b1, 79'(bus.iv)};
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          rnd   <= '0;
          state <= S_INIT;
        end
        S_INIT: begin
          rnd <= rnd + RW'(1);
          if (last_rnd) begin
            state <= S_KS;
          end
        end
        default: begin
          if (bus.start) begin
            kreg  <= bus.key;
            ivreg <= {1'b1, 79'(bus.iv)};
            state <= S_LOAD;
          end
        end
      endcase
    end
  end

  // Shift registers and counter: load from key, mix IV during init, then free-run
  // in KEYSTREAM whenever the packer can take another bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n <= '0;
      l <= '0;
      c <= '0;
    end else if (state == S_LOAD) begin
      n <= kreg[0:36];
      l <= kreg[37:79];
      c <= '0;
    end else if (state == S_INIT) begin
      n <= {n[1:36], g ^ z ^ iv_bit};
      if (last_rnd) begin
        l <= {1'b1, l[2:42], f ^ z ^ iv_bit};
        c <= {n[0:5], l[0]};
      end else begin
        l <= {l[1:42], f ^ z ^ iv_bit};
        c <= c + 7'd1;
      end
    end else if (ks_step) begin
      n <= {n[1:36], g};
      l <= {l[1:42], f};
      c <= c + 7'd1;
    end
  end

  // Word packer: shift z in at the LSB; an accepted word restarts with the new bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack <= '0;
      bcnt <= '0;
    end else if (rekey) begin
      pack <= '0;
      bcnt <= '0;
    end else if (ks_step) begin
      if (accept) begin
        pack <= OUT_W'(z);
        bcnt <= BW'(1);
      end else begin
        pack <= OUT_W'({pack, z});
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  assign bus.busy     = (state == S_LOAD) || (state == S_INIT);
  assign bus.ready    = (state == S_KS);
  assign bus.ks_data  = pack;
  assign bus.ks_valid = ks_valid;

`ifdef FRUIT_XOR_EN
  assign bus.dout = ks_valid ? (bus.din ^ pack) : '0;
`endif

endmodule
